cnn_maxpool_3x3_s2: RTL and testbench
=====================================

CNN_MAXPOOL_3X3_S2 -- requirements
Module: cnn_maxpool_3x3_s2

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, pixel word width (IEEE-754 single); IMAGE_WIDTH, default 128, input columns; IMAGE_HEIGHT, default 128, input rows; CHANNEL_NUM, default 64, channels per image.
REQ-002 Port clk  input  1  sole clock; all state on rising edge.
REQ-003 Port reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 Port valid_in  input  1  pxl_in carries a valid input pixel this cycle.
REQ-005 Port pxl_in  input  DATA_WIDTH  input pixel, raster order within a channel, channels back to back.
REQ-006 Port pxl_out  output  DATA_WIDTH  pooled output pixel.
REQ-007 Port valid_out  output  1  pxl_out valid this cycle.

Function
REQ-008 Block SHALL compute 3x3 max pooling, stride 2, padding 1, per channel; output size (IMAGE_WIDTH/2) x (IMAGE_HEIGHT/2), directly feeding the 64x64 layer1 input stream.
REQ-009 IMAGE_WIDTH and IMAGE_HEIGHT SHALL be even and >= 4; other values unsupported.
REQ-010 Padded positions SHALL be excluded from the max (equivalent to -infinity), never treated as 0.
REQ-011 Output (r,c) SHALL be max of input rows 2r-1..2r+1, cols 2c-1..2c+1, clipped to the image.
REQ-012 Column counter col (0..IMAGE_WIDTH-1), row counter row (0..IMAGE_HEIGHT-1) and channel counter ch (0..CHANNEL_NUM-1) SHALL advance only on valid_in=1 cycles.
REQ-013 col wrap SHALL increment row; row wrap SHALL increment ch; ch wrap SHALL return to 0 with no idle cycle required between channels or images.
REQ-014 Two line buffers of IMAGE_WIDTH words SHALL hold the previous two input rows; contents from a prior channel SHALL never contribute (row 0 of each channel uses padding above).
REQ-015 valid_out SHALL pulse exactly one cycle, registered, 1 clock after the valid_in cycle carrying input pixel (row odd, col odd); no other cycle asserts valid_out.
REQ-016 Output order SHALL be raster within channel, channels in input order; exactly (IMAGE_WIDTH/2)*(IMAGE_HEIGHT/2) outputs per channel.
REQ-017 Gaps in valid_in (any length, any position) SHALL not change output values; pxl_out SHALL hold its last value while valid_out=0.
REQ-018 Max of a,b SHALL follow IEEE-754 ordering: differing signs -> sign-0 operand; both sign 0 -> larger bits[30:0]; both sign 1 -> smaller bits[30:0]; +0 vs -0 -> +0.
REQ-019 NaN/Inf inputs unsupported; denormals SHALL compare by bit pattern per REQ-018.
REQ-020 No backpressure; block SHALL accept valid_in every cycle (throughput 1 pixel/clock).
REQ-021 Output SHALL be bit-exact copy of one input pixel; no arithmetic modification.

Reset
REQ-022 While reset=0: pxl_out=0, valid_out=0, col=row=ch=0, window/column-max registers cleared.
REQ-023 Line-buffer RAM contents need not be cleared; REQ-014 masking SHALL make them irrelevant.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; first valid_in after release SHALL be pixel (0,0) of channel 0.
REQ-025 Reset release SHALL not emit a valid_out pulse.

Verification (IMAGE_WIDTH=IMAGE_HEIGHT=4, CHANNEL_NUM=2 unless noted)
REQ-026 Ramp: channel 0 pixels 1.0..16.0 raster, valid_in every cycle -> outputs 6.0,8.0,14.0,16.0 (0x40C00000,0x41000000,0x41600000,0x41800000), each 1 clock after input pixels 6,8,14,16.
REQ-027 Negative ramp: pixels -1.0..-16.0 -> outputs -1.0,-2.0,-5.0,-6.0 (0xBF800000,0xC0000000,0xC0A00000,0xC0C00000); proves padding not 0.
REQ-028 Gapped: REQ-026 stimulus with valid_in toggling randomly (~50%) -> identical values and order; valid_out never high in a cycle without a preceding qualifying pixel.
REQ-029 Back-to-back channels: channel 0 ramp 1..16 then channel 1 all -3.0 with no gap -> 6,8,14,16 then four -3.0; no channel 0 value leaks.
REQ-030 Reset mid-frame: drive 9 pixels, assert reset 2 cycles, then full REQ-026 ramp -> valid_out/pxl_out 0 during reset, then exactly four outputs 6,8,14,16.
REQ-031 Sign/zero: 2x2 window region containing +0.0 and -0.0 only -> output 0x00000000; region with -0.5 and +0.25 -> 0x3E800000.

Source files
------------

// File: rtl/cnn_maxpool_3x3_s2.sv
// 3x3 / stride-2 / pad-1 max pooling over a raster pixel stream of IEEE-754 words,
// one pixel per clock, channels back to back, one registered output per 2x2 input block.
module cnn_maxpool_3x3_s2 #(
   parameter int DATA_WIDTH   = 32,
   parameter int IMAGE_WIDTH  = 128,
   parameter int IMAGE_HEIGHT = 128,
   parameter int CHANNEL_NUM  = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] pxl_in,
   output logic [DATA_WIDTH-1:0] pxl_out,
   output logic                  valid_out
);

   localparam int COL_W = $clog2(IMAGE_WIDTH);
   localparam int ROW_W = $clog2(IMAGE_HEIGHT);
   localparam int CH_W  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_NUM - 1);

   // IEEE-754 ordering on raw bits; +0 beats -0 because differing signs pick the positive word.
   function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] r;
      if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
         r = a[DATA_WIDTH-1] ? b : a;
      else if (!a[DATA_WIDTH-1])
         r = (a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0]) ? a : b;
      else
         r = (a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0]) ? a : b;
      return r;
   endfunction

   logic [COL_W-1:0]      col;
   logic [ROW_W-1:0]      row;
   logic [CH_W-1:0]       ch;
   logic [DATA_WIDTH-1:0] line_buf1 [IMAGE_WIDTH];
   logic [DATA_WIDTH-1:0] line_buf2 [IMAGE_WIDTH];
   logic [DATA_WIDTH-1:0] col_max1;
   logic [DATA_WIDTH-1:0] col_max2;

   logic [DATA_WIDTH-1:0] lb1_rd;
   logic [DATA_WIDTH-1:0] lb2_rd;
   logic [DATA_WIDTH-1:0] col_max;
   logic [DATA_WIDTH-1:0] win_max;
   logic                  emit;

   assign lb1_rd = line_buf1[col];
   assign lb2_rd = line_buf2[col];
   assign emit   = valid_in && row[0] && col[0];

   // Rows above 0 and columns left of 0 are padding: they are skipped, never compared as zero.
   // NOTE: every always_comb output gets its default first, so no path can infer a latch.
   always_comb begin
      col_max = pxl_in;
      if (row != '0)
         col_max = fp_max(col_max, lb1_rd);
      if (row > ROW_W'(1))
         col_max = fp_max(col_max, lb2_rd);
      win_max = col_max;
      if (col != '0)
         win_max = fp_max(win_max, col_max1);
      if (col > COL_W'(1))
         win_max = fp_max(win_max, col_max2);
   end

   // NOTE: line buffers carry no reset; the row-based masking above keeps stale words out.
   always_ff @(posedge clk) begin
      if (valid_in) begin
         line_buf2[col] <= lb1_rd;
         line_buf1[col] <= pxl_in;
      end
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col      <= '0;
         row      <= '0;
         ch       <= '0;
         col_max1 <= '0;
         col_max2 <= '0;
      end else if (valid_in) begin
         col_max1 <= col_max;
         col_max2 <= col_max1;
         if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
               row <= '0;
               ch  <= (ch == CH_LAST) ? '0 : ch + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pxl_out   <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= emit;
         if (emit)
            pxl_out <= win_max;
      end
   end

endmodule

// File: tb/tb_cnn_maxpool_3x3_s2.sv
// Directed bench for cnn_maxpool_3x3_s2 on a 4x4, two-channel stream; a bench-side
// reference model fills a scoreboard and a negedge monitor checks every cycle.
module tb_cnn_maxpool_3x3_s2;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int NP = W * H;

   typedef logic [31:0] chan_t [NP];

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        valid_in = 1'b0;
   logic [31:0] pxl_in   = '0;
   logic [31:0] pxl_out;
   logic        valid_out;

   cnn_maxpool_3x3_s2 #(
      .DATA_WIDTH  (32),
      .IMAGE_WIDTH (W),
      .IMAGE_HEIGHT(H),
      .CHANNEL_NUM (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .valid_in (valid_in),
      .pxl_in   (pxl_in),
      .pxl_out  (pxl_out),
      .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] sb [$];
   logic [31:0] out_log [$];
   logic [31:0] last_exp = '0;
   logic [31:0] mon_exp;
   logic        drv_q  = 1'b0;
   logic        exp_vo = 1'b0;

   int          m_col = 0;
   int          m_row = 0;
   logic [31:0] img [H][W];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fp_of_int(input int n);
      logic s;
      int   m;
      int   e;
      s = (n < 0);
      m = s ? -n : n;
      if (m == 0)
         return {s, 31'b0};
      e = 0;
      while ((m >> (e + 1)) != 0)
         e++;
      return {s, 8'(127 + e), 23'(m << (23 - e))};
   endfunction

   // Monotonic integer key: larger key means larger float, and +0 outranks -0.
   function automatic logic [31:0] order_key(input logic [31:0] a);
      return a[31] ? ~a : {1'b1, a[30:0]};
   endfunction

   function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
      return (order_key(a) >= order_key(b)) ? a : b;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset)
         exp_vo <= 1'b0;
      else
         exp_vo <= drv_q;
   end

   always @(negedge clk) begin
      if (!reset)
         last_exp = '0;
      check("valid_out", {31'b0, valid_out}, {31'b0, exp_vo});
      if (valid_out === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'(sb.size()), 32'd1);
         end else begin
            mon_exp = sb.pop_front();
            check("pxl_out", pxl_out, mon_exp);
            last_exp = mon_exp;
         end
         out_log.push_back(pxl_out);
      end else begin
         check("pxl_out_hold", pxl_out, last_exp);
      end
   end

   task automatic step(input logic v, input logic [31:0] d);
      logic [31:0] best;
      @(posedge clk);
      #1;
      valid_in = v;
      pxl_in   = d;
      drv_q    = 1'b0;
      if (v) begin
         img[m_row][m_col] = d;
         if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
            best = d;
            for (int rr = m_row - 2; rr <= m_row; rr++)
               for (int cc = m_col - 2; cc <= m_col; cc++)
                  if (rr >= 0 && cc >= 0)
                     best = ref_max(best, img[rr][cc]);
            sb.push_back(best);
            drv_q = 1'b1;
         end
         m_col++;
         if (m_col == W) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, $urandom);
   endtask

   task automatic run_channel(input chan_t px, input bit gapped);
      for (int i = 0; i < NP; i++) begin
         if (gapped) begin
            for (int g = 0; g < 5 && ($urandom % 2) == 1; g++)
               step(1'b0, $urandom);
         end
         step(1'b1, px[i]);
      end
   endtask

   task automatic check_log(input string tag, input int base, input logic [31:0] e0,
                            input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int i = 0; i < 4; i++)
         if (base + i < out_log.size())
            check(tag, out_log[base + i], e[i]);
         else
            check({tag, "_missing"}, 32'(out_log.size()), 32'(base + i + 1));
   endtask

   chan_t ramp, neg_ramp, all_m3, sgn, rnd;

   initial begin
      for (int i = 0; i < NP; i++) begin
         ramp[i]      = fp_of_int(i + 1);
         neg_ramp[i]  = fp_of_int(-(i + 1));
         all_m3[i]    = 32'hC040_0000;
         sgn[i]       = 32'hBF00_0000;
         rnd[i]       = $urandom;
         rnd[i][30:23] = 8'($urandom_range(1, 254));
      end
      sgn[0]  = 32'h8000_0000;
      sgn[1]  = 32'h0000_0000;
      sgn[4]  = 32'h8000_0000;
      sgn[5]  = 32'h8000_0000;
      sgn[12] = 32'h3E80_0000;

      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      idle(2);

      // Ramp, valid every cycle, then a constant channel straight after with no gap.
      out_log.delete();
      run_channel(ramp, 1'b0);
      run_channel(all_m3, 1'b0);
      idle(2);
      check("ramp_count", 32'(out_log.size()), 32'd8);
      check_log("ramp", 0, 32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000);
      check_log("b2b_ch1", 4, 32'hC040_0000, 32'hC040_0000, 32'hC040_0000, 32'hC040_0000);

      out_log.delete();
      run_channel(neg_ramp, 1'b0);
      idle(2);
      check_log("neg_ramp", 0, 32'hBF80_0000, 32'hC000_0000, 32'hC0A0_0000, 32'hC0C0_0000);

      out_log.delete();
      run_channel(ramp, 1'b1);
      idle(2);
      check("gapped_count", 32'(out_log.size()), 32'd4);
      check_log("gapped", 0, 32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000);

      out_log.delete();
      run_channel(sgn, 1'b0);
      idle(2);
      check_log("sign_zero", 0, 32'h0000_0000, 32'h0000_0000, 32'h3E80_0000, 32'h8000_0000);

      run_channel(rnd, 1'b1);
      idle(2);

      // Abandon a frame mid-way: nine pixels, two reset cycles, then a clean ramp.
      for (int i = 0; i < 9; i++)
         step(1'b1, ramp[i]);
      idle(1);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      valid_in = 1'b0;
      drv_q    = 1'b0;
      sb.delete();
      m_col = 0;
      m_row = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      out_log.delete();
      run_channel(ramp, 1'b0);
      idle(3);
      check("reset_count", 32'(out_log.size()), 32'd4);
      check_log("after_reset", 0, 32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000);

      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
